// File: rtl/cache_pkg.sv
// Shared types and constants for the MEM-stage 2-way data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Address layout: offset [2:0], index [8:3], tag [18:9].
package cache_pkg;

    localparam int TAG_W   = 10;
    localparam int IDX_W   = 6;
    localparam int OFF_W   = 3;

    localparam int OFF_LSB = 0;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    // Bit of the byte offset that selects the upper 32-bit half of a line.
    localparam int HALF_BIT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR      = 2'd3
    } state_t;

    // Replace one 32-bit half of a 64-bit line.
    function automatic logic [63:0] merge_word(input logic [63:0] line,
                                               input logic [31:0] word,
                                               input logic        upper);
        logic [63:0] res;
        res = line;
        if (upper) res[63:32] = word;
        else       res[31:0]  = word;
        return res;
    endfunction

endpackage

// File: rtl/cache_lru_table.sv
// Per-set LRU bit store: lru[i] names the next way to replace in set i.
// Latency: combinational read, update visible the cycle after upd_en.
// Backpressure: none; one update per cycle, synchronous clear on rst.
//
// Ports: clk/rst; rd_index -> rd_way (read port);
//        upd_en/upd_index/upd_way (way just used; stored value is its complement).
module cache_lru_table
    import cache_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_way,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_way
);

    logic [SETS-1:0] lru_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lru_q <= '0;
        end else if (upd_en) begin
            // The way just touched becomes most recent, so the other is next victim.
            lru_q[upd_index] <= ~upd_way;
        end
    end

    assign rd_way = lru_q[rd_index];

endmodule

// File: rtl/cache_fill_controller.sv
// Fill/write side of the 2-way data cache: miss fills, write-through, LRU, pipeline freeze.
// Latency: read hit 0 cycles; read miss SRAM latency + FILL cycle; write completes on sram_ready.
// Backpressure: ready=0 freezes the pipeline while an SRAM transaction is outstanding.
//
// Ports: clk, rst (sync, active high); pipeline side rd_en/wr_en/addr/wr_data, ready, rd_data;
//        lookup side hit/hit_way0/hit_way1/valid_way0/valid_way1/hit_data;
//        SRAM side sram_req/sram_we/sram_addr/sram_wdata/sram_ready/sram_rdata;
//        array side fill_en/fill_way/fill_index/fill_tag/fill_data/inval_en/inval_way.
// Option CACHE_WRITE_UPDATE_EN: write hits update the line in place (needs hit_line input)
//        instead of invalidating it.
module cache_fill_controller
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [31:0]      addr,
    input  logic [31:0]      wr_data,
    input  logic             hit,
    input  logic             hit_way0,
    input  logic             hit_way1,
    input  logic             valid_way0,
    input  logic             valid_way1,
    input  logic [31:0]      hit_data,
`ifdef CACHE_WRITE_UPDATE_EN
    input  logic [63:0]      hit_line,
`endif
    output logic [31:0]      rd_data,
    output logic             ready,
    output logic             sram_req,
    output logic             sram_we,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic             sram_ready,
    input  logic [63:0]      sram_rdata,
    output logic             fill_en,
    output logic             fill_way,
    output logic [IDX_W-1:0] fill_index,
    output logic [TAG_W-1:0] fill_tag,
    output logic [63:0]      fill_data,
    output logic             inval_en,
    output logic             inval_way
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [63:0] line_q;
    logic        way_q;
`ifdef CACHE_WRITE_UPDATE_EN
    logic        hit_q;
    logic [63:0] hit_line_q;
`endif

    logic [IDX_W-1:0] cur_index;
    logic [IDX_W-1:0] q_index;
    logic [TAG_W-1:0] q_tag;
    logic             hit_way_sel;
    logic             lru_way;
    logic             victim;
    logic             lru_upd_en;
    logic             lru_upd_way;

    assign cur_index   = addr[IDX_LSB +: IDX_W];
    assign q_index     = addr_q[IDX_LSB +: IDX_W];
    assign q_tag       = addr_q[TAG_LSB +: TAG_W];
    assign hit_way_sel = hit_way1 & ~hit_way0;

    // Prefer an empty way; only fall back to LRU when the set is full.
    assign victim = !valid_way0 ? 1'b0 :
                    !valid_way1 ? 1'b1 : lru_way;

    cache_lru_table #(.SETS(SETS)) u_lru (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (cur_index),
        .rd_way    (lru_way),
        .upd_en    (lru_upd_en),
        .upd_index (state_q == FILL ? q_index : cur_index),
        .upd_way   (lru_upd_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
            way_q   <= 1'b0;
`ifdef CACHE_WRITE_UPDATE_EN
            hit_q      <= 1'b0;
            hit_line_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        addr_q  <= addr;
                        wdata_q <= wr_data;
                        way_q   <= hit_way_sel;
`ifdef CACHE_WRITE_UPDATE_EN
                        hit_q      <= hit;
                        hit_line_q <= hit_line;
`endif
                    end else if (rd_en && !hit) begin
                        addr_q <= addr;
                        way_q  <= victim;
                    end
                end
                RD_MISS: begin
                    if (sram_ready) line_q <= sram_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        ready       = 1'b1;
        rd_data     = '0;
        sram_req    = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        fill_en     = 1'b0;
        fill_way    = 1'b0;
        fill_index  = '0;
        fill_tag    = '0;
        fill_data   = '0;
        inval_en    = 1'b0;
        inval_way   = 1'b0;
        lru_upd_en  = 1'b0;
        lru_upd_way = 1'b0;

        // While rst is high every strobe is held low so an in-flight request drops at once.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        ready   = 1'b0;
                        state_d = WR;
`ifndef CACHE_WRITE_UPDATE_EN
                        if (hit) begin
                            inval_en   = 1'b1;
                            inval_way  = hit_way_sel;
                            fill_index = cur_index;
                        end
`endif
                    end else if (rd_en) begin
                        if (hit) begin
                            rd_data     = hit_data;
                            lru_upd_en  = 1'b1;
                            lru_upd_way = hit_way_sel;
                        end else begin
                            ready   = 1'b0;
                            state_d = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    ready     = 1'b0;
                    sram_req  = 1'b1;
                    sram_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                    if (sram_ready) state_d = FILL;
                end
                FILL: begin
                    fill_en     = 1'b1;
                    fill_way    = way_q;
                    fill_index  = q_index;
                    fill_tag    = q_tag;
                    fill_data   = line_q;
                    rd_data     = addr_q[HALF_BIT] ? line_q[63:32] : line_q[31:0];
                    lru_upd_en  = 1'b1;
                    lru_upd_way = way_q;
                    state_d     = IDLE;
                end
                WR: begin
                    ready      = 1'b0;
                    sram_req   = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = addr_q;
                    sram_wdata = wdata_q;
                    if (sram_ready) begin
                        ready   = 1'b1;
                        state_d = IDLE;
`ifdef CACHE_WRITE_UPDATE_EN
                        // Write-update keeps the line resident; LRU is left alone.
                        if (hit_q) begin
                            fill_en    = 1'b1;
                            fill_way   = way_q;
                            fill_index = q_index;
                            fill_tag   = q_tag;
                            fill_data  = merge_word(hit_line_q, wdata_q, addr_q[HALF_BIT]);
                        end
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed self-checking bench for cache_fill_controller (default build).
// Latency: n/a.
// Backpressure: SRAM completion pulses are driven at fixed directed delays.
module tb_cache_fill_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wr_data;
    logic        hit, hit_way0, hit_way1, valid_way0, valid_way1;
    logic [31:0] hit_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        sram_req, sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_ready;
    logic [63:0] sram_rdata;
    logic        fill_en, fill_way;
    logic [5:0]  fill_index;
    logic [9:0]  fill_tag;
    logic [63:0] fill_data;
    logic        inval_en, inval_way;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_fill_controller #(.SETS(64), .TAG_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .hit        (hit),
        .hit_way0   (hit_way0),
        .hit_way1   (hit_way1),
        .valid_way0 (valid_way0),
        .valid_way1 (valid_way1),
        .hit_data   (hit_data),
        .rd_data    (rd_data),
        .ready      (ready),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ready (sram_ready),
        .sram_rdata (sram_rdata),
        .fill_en    (fill_en),
        .fill_way   (fill_way),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .inval_en   (inval_en),
        .inval_way  (inval_way)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and return just after the edge, ready to drive.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge, away from the active edge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_en = 0; wr_en = 0; addr = 0; wr_data = 0;
        hit = 0; hit_way0 = 0; hit_way1 = 0; valid_way0 = 0; valid_way1 = 0;
        hit_data = 0; sram_ready = 0; sram_rdata = 0;
    endtask

    function automatic int lru_popcount();
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(dut.u_lru.lru_q[i]);
        return n;
    endfunction

    // Full read-miss sequence with SRAM completing in the n-th RD_MISS cycle.
    task automatic read_miss(input string nm, input logic [31:0] a, input logic v0, input logic v1,
                             input int n, input logic [63:0] line, input logic [31:0] exp_saddr,
                             input logic exp_way, input logic [5:0] exp_idx,
                             input logic [9:0] exp_tag, input logic [31:0] exp_rd);
        rd_en = 1; addr = a; hit = 0; valid_way0 = v0; valid_way1 = v1;
        settle();
        chk({nm, "_detect_ready"}, 64'(ready), 64'd0);
        chk({nm, "_detect_req"}, 64'(sram_req), 64'd0);
        step();
        for (int k = 1; k <= n; k++) begin
            if (k == n) begin sram_ready = 1; sram_rdata = line; end
            settle();
            chk({nm, "_req"}, 64'(sram_req), 64'd1);
            chk({nm, "_ready_low"}, 64'(ready), 64'd0);
            if (k == 1) begin
                chk({nm, "_we"}, 64'(sram_we), 64'd0);
                chk({nm, "_saddr"}, 64'(sram_addr), 64'(exp_saddr));
            end
            step();
        end
        sram_ready = 0; sram_rdata = 0;
        settle();
        chk({nm, "_fill_en"}, 64'(fill_en), 64'd1);
        chk({nm, "_fill_way"}, 64'(fill_way), 64'(exp_way));
        chk({nm, "_fill_index"}, 64'(fill_index), 64'(exp_idx));
        chk({nm, "_fill_tag"}, 64'(fill_tag), 64'(exp_tag));
        chk({nm, "_fill_data"}, fill_data, line);
        chk({nm, "_fill_ready"}, 64'(ready), 64'd1);
        chk({nm, "_rd_data"}, 64'(rd_data), 64'(exp_rd));
        chk({nm, "_fill_req"}, 64'(sram_req), 64'd0);
        step();
        rd_en = 0; valid_way0 = 0; valid_way1 = 0;
    endtask

    task automatic read_hit(input string nm, input logic [31:0] a, input logic w1,
                            input logic [31:0] d, input logic exp_lru);
        logic [5:0] idx;
        idx = a[8:3];
        rd_en = 1; addr = a; hit = 1; hit_way0 = ~w1; hit_way1 = w1;
        valid_way0 = 1; valid_way1 = 1; hit_data = d;
        settle();
        chk({nm, "_ready"}, 64'(ready), 64'd1);
        chk({nm, "_rd_data"}, 64'(rd_data), 64'(d));
        chk({nm, "_req"}, 64'(sram_req), 64'd0);
        step();
        idle_inputs();
        chk({nm, "_lru"}, 64'(dut.u_lru.lru_q[idx]), 64'(exp_lru));
    endtask

    task automatic write_req(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input logic h, input logic w1, input int n);
        wr_en = 1; addr = a; wr_data = d; hit = h; hit_way0 = h & ~w1; hit_way1 = h & w1;
        valid_way0 = 1; valid_way1 = 1;
        settle();
        chk({nm, "_inval_en"}, 64'(inval_en), 64'(h));
        if (h) begin
            chk({nm, "_inval_way"}, 64'(inval_way), 64'(w1));
            chk({nm, "_inval_index"}, 64'(fill_index), 64'(a[8:3]));
        end
        chk({nm, "_detect_ready"}, 64'(ready), 64'd0);
        step();
        for (int k = 1; k <= n; k++) begin
            if (k == n) sram_ready = 1;
            settle();
            chk({nm, "_we"}, 64'(sram_we), 64'd1);
            chk({nm, "_saddr"}, 64'(sram_addr), 64'(a));
            chk({nm, "_wdata"}, 64'(sram_wdata), 64'(d));
            chk({nm, "_ready"}, 64'(ready), 64'(k == n));
            chk({nm, "_no_inval"}, 64'(inval_en), 64'd0);
            step();
        end
        idle_inputs();
        settle();
        chk({nm, "_after_req"}, 64'(sram_req), 64'd0);
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        settle();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_req", 64'(sram_req), 64'd0);
        chk("rst_we", 64'(sram_we), 64'd0);
        chk("rst_fill_en", 64'(fill_en), 64'd0);
        chk("rst_inval_en", 64'(inval_en), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_saddr", 64'(sram_addr), 64'd0);
        chk("rst_fill_data", fill_data, 64'd0);
        chk("rst_lru_pop", 64'(lru_popcount()), 64'd0);
        step();

        // Stray completion pulse in IDLE must be ignored.
        sram_ready = 1; sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        settle();
        chk("idle_sram_ready_ready", 64'(ready), 64'd1);
        step();
        idle_inputs();
        settle();
        chk("idle_sram_ready_fill", 64'(fill_en), 64'd0);
        step();

        // Empty set: victim way0, low word, lru[1] becomes 1.
        read_miss("miss1", 32'h0000_0208, 0, 0, 4, 64'h1111_2222_3333_4444,
                  32'h0000_0208, 1'b0, 6'd1, 10'd1, 32'h3333_4444);
        chk("miss1_lru1", 64'(dut.u_lru.lru_q[1]), 64'd1);

        // Full set, lru[1]=1: victim way1; offset 0xC selects upper word, line-aligned address.
        read_miss("miss2", 32'h0000_040C, 1, 1, 2, 64'hAAAA_BBBB_CCCC_DDDD,
                  32'h0000_0408, 1'b1, 6'd1, 10'd2, 32'hAAAA_BBBB);
        chk("miss2_lru1", 64'(dut.u_lru.lru_q[1]), 64'd0);

        // Only way1 empty: victim way1 regardless of lru.
        read_miss("miss3", 32'h0000_0A18, 1, 0, 1, 64'h0123_4567_89AB_CDEF,
                  32'h0000_0A18, 1'b1, 6'd3, 10'd5, 32'h89AB_CDEF);
        chk("miss3_lru3", 64'(dut.u_lru.lru_q[3]), 64'd0);

        // Hits at index 33: way0 -> 1, way1 -> 0, way0 -> 1.
        read_hit("hit_w0a", 32'h0000_0108, 1'b0, 32'h5A5A_1234, 1'b1);
        read_hit("hit_w1", 32'h0000_0108, 1'b1, 32'hC0FF_EE01, 1'b0);
        read_hit("hit_w0b", 32'h0000_010C, 1'b0, 32'h7777_0000, 1'b1);

        // Write hit way0 invalidates, write-through, LRU untouched.
        write_req("wr_hit0", 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 3);
        chk("wr_hit0_lru2", 64'(dut.u_lru.lru_q[2]), 64'd0);
        write_req("wr_hit1", 32'h0000_0214, 32'h0BAD_F00D, 1'b1, 1'b1, 2);
        chk("wr_hit1_lru2", 64'(dut.u_lru.lru_q[2]), 64'd0);
        write_req("wr_miss", 32'h0000_0304, 32'h1234_5678, 1'b0, 1'b0, 1);

        // Write wins over a simultaneous read.
        rd_en = 1; wr_en = 1; addr = 32'h0000_0040; wr_data = 32'h5555_AAAA; hit = 0;
        settle();
        chk("wr_prio_ready", 64'(ready), 64'd0);
        step();
        settle();
        chk("wr_prio_we", 64'(sram_we), 64'd1);
        sram_ready = 1;
        step();
        idle_inputs();

        // Reset in the middle of a read miss.
        rd_en = 1; addr = 32'h0000_0208; hit = 0;
        step();
        settle();
        chk("rstmid_req_before", 64'(sram_req), 64'd1);
        step();
        rst = 1; sram_ready = 1; sram_rdata = 64'h9999_8888_7777_6666;
        settle();
        chk("rstmid_req_drop", 64'(sram_req), 64'd0);
        chk("rstmid_fill_en", 64'(fill_en), 64'd0);
        step();
        rst = 0; idle_inputs();
        settle();
        chk("rstmid_idle_ready", 64'(ready), 64'd1);
        chk("rstmid_idle_req", 64'(sram_req), 64'd0);
        chk("rstmid_idle_fill", 64'(fill_en), 64'd0);
        chk("rstmid_lru_pop", 64'(lru_popcount()), 64'd0);
        step();
        settle();
        chk("rstmid_late_fill", 64'(fill_en), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
